iter_alu: RTL and testbench

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/alu_pkg.sv | 29 ++
 rtl/iter_mul.sv | 59 +++++
 rtl/iter_alu.sv | 123 ++++++++++++
 tb/tb_iter_alu.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op-code and FSM state definitions for the iterative ALU.
// The ALU control decoder and the top-level FSM both draw on these encodings.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_XOR  = 3'd1,
        OP_SLL  = 3'd2,
        OP_SUB  = 3'd3,
        OP_MUL  = 3'd4,
        OP_SRA  = 3'd5,
        OP_AND  = 3'd6,
        OP_RSVD = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    localparam int SHAMT_W = 5;
    localparam int MUL_STEPS = 32;

    function automatic logic is_mul_op(input logic [2:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/iter_mul.sv
// Shift-add multiplier: one partial-product step per cycle, 32 steps per product.
// done is asserted combinationally in the cycle whose edge completes the last step.
module iter_mul
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              flush,
    input  logic [DATA_W-1:0] multiplicand,
    input  logic [DATA_W-1:0] multiplier,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    logic              busy;
    logic [4:0]        step_cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc_sum;

    always_comb begin
        acc_sum = mplier[0] ? (acc + mcand) : acc;
        done    = busy && (step_cnt == 5'(MUL_STEPS - 1));
        product = acc_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            step_cnt <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
        end else if (flush) begin
            busy     <= 1'b0;
            step_cnt <= '0;
            acc      <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            step_cnt <= '0;
            acc      <= '0;
            mcand    <= multiplicand;
            mplier   <= multiplier;
        end else if (busy) begin
            acc      <= acc_sum;
            mcand    <= mcand << 1;
            mplier   <= mplier >> 1;
            step_cnt <= step_cnt + 5'd1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arith ops, 32-cycle shift-add multiply,
// valid/ready on both sides with a registered result held until accepted.
module iter_alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [2:0]        ALUCtrl_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              flush_i,
    output logic [DATA_W-1:0] data_o,
    output logic              zero_o,
    output logic              valid_o,
    input  logic              ready_i
);

    alu_state_e        state;
    alu_state_e        state_next;
    logic              accept;
    logic              mul_start;
    logic              load_alu;
    logic              load_mul;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;
    logic [DATA_W-1:0] alu_result;
    logic [SHAMT_W-1:0] shamt;

    assign ready_o = (state == ST_IDLE) && rst_i;
    assign valid_o = (state == ST_DONE);
    assign accept  = valid_i && ready_o;
    assign shamt   = data2_i[SHAMT_W-1:0];

    // Single-cycle result path; MUL and the reserved code fall through to zero.
    always_comb begin
        alu_result = '0;
        case (ALUCtrl_i)
            OP_ADD:  alu_result = data1_i + data2_i;
            OP_XOR:  alu_result = data1_i ^ data2_i;
            OP_SLL:  alu_result = data1_i << shamt;
            OP_SUB:  alu_result = data1_i - data2_i;
            OP_SRA:  alu_result = DATA_W'($signed(data1_i) >>> shamt);
            OP_AND:  alu_result = data1_i & data2_i;
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush outranks both accept and the result handshake.
    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        load_alu   = 1'b0;
        load_mul   = 1'b0;
        if (flush_i) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mul_op(ALUCtrl_i)) begin
                            mul_start  = 1'b1;
                            state_next = ST_MUL;
                        end else begin
                            load_alu   = 1'b1;
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        load_mul   = 1'b1;
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o <= '0;
            zero_o <= 1'b1;
        end else if (load_alu) begin
            data_o <= alu_result;
            zero_o <= (alu_result == '0);
        end else if (load_mul) begin
            data_o <= mul_product;
            zero_o <= (mul_product == '0);
        end
    end

    iter_mul #(
        .DATA_W(DATA_W)
    ) u_iter_mul (
        .clk         (clk_i),
        .rst_n       (rst_i),
        .start       (mul_start),
        .flush       (flush_i),
        .multiplicand(data1_i),
        .multiplier  (data2_i),
        .done        (mul_done),
        .product     (mul_product)
    );

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu; inputs driven and outputs sampled
// on the falling clock edge, expected values hand-computed.
module tb_iter_alu;

    localparam int DATA_W = 32;

    logic              clk_i;
    logic              rst_i;
    logic [2:0]        ALUCtrl_i;
    logic [DATA_W-1:0] data1_i;
    logic [DATA_W-1:0] data2_i;
    logic              valid_i;
    logic              ready_o;
    logic              flush_i;
    logic [DATA_W-1:0] data_o;
    logic              zero_o;
    logic              valid_o;
    logic              ready_i;

    int total = 0;
    int bad   = 0;

    iter_alu #(.DATA_W(DATA_W)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ALUCtrl_i(ALUCtrl_i),
        .data1_i  (data1_i),
        .data2_i  (data2_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .flush_i  (flush_i),
        .data_o   (data_o),
        .zero_o   (zero_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with ready_o high; returns at the falling edge after the accept.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        ALUCtrl_i = op;
        data1_i   = a;
        data2_i   = b;
        valid_i   = 1'b1;
        @(negedge clk_i);
        valid_i   = 1'b0;
        ALUCtrl_i = 3'($urandom_range(0, 7));
        data1_i   = $urandom;
        data2_i   = $urandom;
    endtask

    task automatic waitValid(input string tag, input int budget, output int cycles);
        int ready_seen;
        cycles = 1;
        ready_seen = 0;
        while (!valid_o && cycles < budget) begin
            if (ready_o) ready_seen = 1;
            @(negedge clk_i);
            cycles++;
        end
        checkOutput({tag, "_ready_low"}, 32'(ready_seen), 32'd0);
    endtask

    initial begin
        int cycles;
        int valid_seen;

        rst_i     = 1'b0;
        ALUCtrl_i = 3'd0;
        data1_i   = '0;
        data2_i   = '0;
        valid_i   = 1'b0;
        flush_i   = 1'b0;
        ready_i   = 1'b1;

        repeat (2) @(negedge clk_i);
        checkOutput("rst_data", data_o, 32'h0);
        checkOutput("rst_zero", 32'(zero_o), 32'd1);
        checkOutput("rst_valid", 32'(valid_o), 32'd0);
        checkOutput("rst_ready", 32'(ready_o), 32'd0);
        rst_i = 1'b1;
        #1;
        checkOutput("rel_ready", 32'(ready_o), 32'd1);
        @(negedge clk_i);

        // ADD overflow wraps into the sign bit
        applyStimulus(3'd0, 32'h7FFF_FFFF, 32'h1);
        checkOutput("add_valid", 32'(valid_o), 32'd1);
        checkOutput("add_data", data_o, 32'h8000_0000);
        checkOutput("add_zero", 32'(zero_o), 32'd0);
        checkOutput("add_ready", 32'(ready_o), 32'd0);
        @(negedge clk_i);
        checkOutput("add_idle_valid", 32'(valid_o), 32'd0);
        checkOutput("add_idle_ready", 32'(ready_o), 32'd1);

        // SUB to zero with downstream stalling
        ready_i = 1'b0;
        applyStimulus(3'd3, 32'd5, 32'd5);
        for (int i = 0; i < 4; i++) begin
            checkOutput("sub_hold_valid", 32'(valid_o), 32'd1);
            checkOutput("sub_hold_data", data_o, 32'h0);
            checkOutput("sub_hold_zero", 32'(zero_o), 32'd1);
            @(negedge clk_i);
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("sub_idle_valid", 32'(valid_o), 32'd0);
        checkOutput("sub_idle_ready", 32'(ready_o), 32'd1);

        // MUL with truncated product
        ready_i = 1'b0;
        applyStimulus(3'd4, 32'hFFFF_FFFF, 32'd3);
        waitValid("mul", 40, cycles);
        checkOutput("mul_latency", 32'(cycles), 32'd33);
        checkOutput("mul_data", data_o, 32'hFFFF_FFFD);
        checkOutput("mul_zero", 32'(zero_o), 32'd0);
        ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("mul_idle_valid", 32'(valid_o), 32'd0);

        applyStimulus(3'd5, 32'h8000_0000, 32'd31);
        checkOutput("sra_data", data_o, 32'hFFFF_FFFF);
        @(negedge clk_i);
        applyStimulus(3'd2, 32'h1, 32'h25);
        checkOutput("sll_data", data_o, 32'h0000_0020);
        @(negedge clk_i);
        applyStimulus(3'd1, 32'h0000_F0F0, 32'h0000_FF00);
        checkOutput("xor_data", data_o, 32'h0000_0FF0);
        @(negedge clk_i);
        applyStimulus(3'd6, 32'h0000_F0F0, 32'h0000_FF00);
        checkOutput("and_data", data_o, 32'h0000_F000);
        @(negedge clk_i);
        applyStimulus(3'd7, 32'd5, 32'd6);
        checkOutput("rsvd_valid", 32'(valid_o), 32'd1);
        checkOutput("rsvd_data", data_o, 32'h0);
        checkOutput("rsvd_zero", 32'(zero_o), 32'd1);
        @(negedge clk_i);

        // Flush a multiply partway through; no result may appear
        applyStimulus(3'd4, 32'd7, 32'd6);
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        checkOutput("flush_ready", 32'(ready_o), 32'd1);
        valid_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o) valid_seen = 1;
            @(negedge clk_i);
        end
        checkOutput("flush_no_valid", 32'(valid_seen), 32'd0);
        applyStimulus(3'd0, 32'd2, 32'd3);
        checkOutput("post_flush_valid", 32'(valid_o), 32'd1);
        checkOutput("post_flush_data", data_o, 32'd5);
        @(negedge clk_i);

        // Asynchronous reset in the middle of a multiply
        applyStimulus(3'd4, 32'd9, 32'd9);
        repeat (5) @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        checkOutput("arst_data", data_o, 32'h0);
        checkOutput("arst_zero", 32'(zero_o), 32'd1);
        checkOutput("arst_valid", 32'(valid_o), 32'd0);
        checkOutput("arst_ready", 32'(ready_o), 32'd0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checkOutput("arst_rel_ready", 32'(ready_o), 32'd1);
        valid_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (valid_o) valid_seen = 1;
        end
        checkOutput("arst_no_valid", 32'(valid_seen), 32'd0);
        applyStimulus(3'd4, 32'd6, 32'd7);
        waitValid("mul2", 40, cycles);
        checkOutput("mul2_latency", 32'(cycles), 32'd33);
        checkOutput("mul2_data", data_o, 32'd42);
        @(negedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

endmodule
